gng_cmplx_stats: RTL and testbench
==================================

// Module: gng_cmplx_stats
// PURPOSE
//  Sink-side statistics engine for complex s<16,11> noise streams (gng_cmplx output).
//  On start, accepts exactly N=2^LOG2_N valid samples. Reports:
//    - per-component mean;
//    - mean power E[re^2+im^2];
//    - count of tail excursions |x|>=THRESH.
//  Used in BIST and as a run-time health monitor for noise-injection paths.
// PARAMETERS
//  LOG2_N   10          log2 of samples per measurement (1..16)
//  THRESH   16'sd6144   tail threshold, s<16,11> (6144 = 3.0 sigma for unit-variance component)
// PORTS
//  clk       in   1            system clock
//  rstn      in   1            asynchronous reset, active low
//  start     in   1            begin measurement; honoured only when busy=0
//  valid_in  in   1            sample strobe; honoured only in ACCUM
//  real_in   in   16           real sample, s<16,11>
//  imag_in   in   16           imag sample, s<16,11>
//  busy      out  1            measurement in progress (state != IDLE)
//  done      out  1            one-cycle pulse: result registers updated
//  mean_re   out  16           sum(real)>>>LOG2_N, s<16,11>
//  mean_im   out  16           sum(imag)>>>LOG2_N, s<16,11>
//  pwr       out  32           sum(re^2+im^2)>>LOG2_N, u<32,22>
//  tail_cnt  out  LOG2_N+2     component samples with |x|>=THRESH (0..2N)
// BEHAVIOUR
//  Reset: all outputs and internal state 0, FSM=IDLE; async assert, sync-safe deassert.
//  FSM: IDLE -start-> ACCUM (accumulators, sample counter, tail counter cleared).
//       ACCUM -Nth accepted sample-> FLUSH.
//       FLUSH (2 cycles, pipeline drain) -> IDLE; done=1 and outputs load in that IDLE cycle.
//  Pipeline: S1 registers inputs + tail flags; S2 squares (signed 16x16 -> 32);
//    S3 accumulates. Nth sample presented at cycle k -> done high at cycle k+3.
//  Gaps: valid_in may drop any number of cycles in ACCUM; only valid cycles count.
//    Result is independent of gap pattern.
//  Widths:
//    sum_re/sum_im: 16+LOG2_N signed, no overflow possible.
//    re^2+im^2: 32 unsigned; max 2^31 at (-32768,-32768), no saturation needed.
//    power acc: 32+LOG2_N unsigned.
//    Means: arithmetic shift, truncation toward -inf. pwr: logical shift, truncation.
//  Tail test: x>=THRESH || x<=-THRESH (no abs(), so -32768 is safe).
//    re and im each add 1 -> per-sample increment 0..2.
//  Outputs hold last result until the next done. They are not cleared by start.
//  start while busy: ignored.
//  start in the done cycle: accepted (busy=1 next cycle).
//  valid_in outside ACCUM: ignored, no pipeline effect.
//  The valid_in cycle that completes sample N is the last accepted; later strobes are ignored.
//  rstn low mid-measurement: immediate abort, outputs 0, no done; next start measures afresh.
// STRUCTURE
//  gng_pkg (shared with gng/gng_cmplx):
//    typedef logic signed [15:0] gng_sample_t;
//    localparam GNG_FRAC=11;
//    stats FSM enum {IDLE,ACCUM,FLUSH}.
//  Sub-module gng_cmplx_power: registered S1/S2 stage (input reg, tail flags, squares, re^2+im^2)
//    with valid pipe; parent owns FSM, counters, accumulators.
// TESTING (LOG2_N=4, N=16 unless noted)
//  1 Constant re=2048 (1.0), im=-2048 -> mean_re=2048, mean_im=-2048, pwr=8388608 (2.0), tail_cnt=0.
//  2 re alternating +/-6144, im=0 -> mean_re=0, mean_im=0, pwr=37748736 (9.0), tail_cnt=16.
//  3 re=im=-32768 -> mean_re=mean_im=-32768, pwr=2147483648, tail_cnt=32.
//  4 Test 1 with valid_in every 3rd cycle -> identical results; done exactly 3 cycles after 16th valid.
//  5 Control: start while busy ignored; start in done cycle restarts; valid_in in IDLE ignored;
//    rstn pulse mid-ACCUM -> all outputs 0, no done, fresh start correct.
//  6 Driven by gng_cmplx, LOG2_N=14 -> |mean_re|,|mean_im| < 64; pwr within 8388608 +/-5%;
//    tail_cnt in 60..120 (expected ~88).

Source files
------------

// File: rtl/gng_pkg.sv
// Shared types for the Gaussian noise generator family and its sink-side statistics engine.
package gng_pkg;

  typedef logic signed [15:0] gng_sample_t;

  localparam int GNG_FRAC = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } stats_state_t;

  // Two-sided compare instead of abs() so that -32768 cannot overflow.
  function automatic logic is_tail(input gng_sample_t x, input gng_sample_t th);
    return (x >= th) || (x <= -th);
  endfunction

endpackage

// File: rtl/gng_cmplx_power.sv
// Front of the statistics pipeline: S1 registers the sample and its tail flags,
// S2 registers re^2+im^2 with the tail count and the sample itself.
module gng_cmplx_power
  import gng_pkg::*;
#(
  parameter gng_sample_t THRESH = 16'sd6144
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        vld_i,
  input  gng_sample_t re_i,
  input  gng_sample_t im_i,
  output logic        vld_o,
  output gng_sample_t re_o,
  output gng_sample_t im_o,
  output logic [31:0] pwr_o,
  output logic [1:0]  tail_o
);

  logic        vld_p1_q, tail_re_p1_q, tail_im_p1_q;
  gng_sample_t re_p1_q, im_p1_q;
  logic        vld_p2_q;
  gng_sample_t re_p2_q, im_p2_q;
  logic [31:0] pwr_p2_q;
  logic [1:0]  tail_p2_q;

  logic signed [31:0] re_ext, im_ext, re_sq, im_sq;
  logic [31:0]        pwr_d;
  logic [1:0]         tail_d;

  // S1: capture accepted samples only; idle cycles leave the registers untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1_q     <= 1'b0;
      re_p1_q      <= '0;
      im_p1_q      <= '0;
      tail_re_p1_q <= 1'b0;
      tail_im_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_i;
      if (vld_i) begin
        re_p1_q      <= re_i;
        im_p1_q      <= im_i;
        tail_re_p1_q <= is_tail(re_i, THRESH);
        tail_im_p1_q <= is_tail(im_i, THRESH);
      end
    end
  end

  // Each square is at most 2^30, so the unsigned sum peaks at exactly 2^31.
  always_comb begin
    re_ext = {{16{re_p1_q[15]}}, re_p1_q};
    im_ext = {{16{im_p1_q[15]}}, im_p1_q};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    pwr_d  = $unsigned(re_sq) + $unsigned(im_sq);
    tail_d = {1'b0, tail_re_p1_q} + {1'b0, tail_im_p1_q};
  end

  // S2: power and tail count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2_q  <= 1'b0;
      re_p2_q   <= '0;
      im_p2_q   <= '0;
      pwr_p2_q  <= '0;
      tail_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        re_p2_q   <= re_p1_q;
        im_p2_q   <= im_p1_q;
        pwr_p2_q  <= pwr_d;
        tail_p2_q <= tail_d;
      end
    end
  end

  assign vld_o  = vld_p2_q;
  assign re_o   = re_p2_q;
  assign im_o   = im_p2_q;
  assign pwr_o  = pwr_p2_q;
  assign tail_o = tail_p2_q;

endmodule

// File: rtl/gng_cmplx_stats.sv
// Measures mean, mean power and tail-excursion count over 2^LOG2_N complex samples;
// owns the control FSM, the S3 accumulators and the held result registers.
module gng_cmplx_stats
  import gng_pkg::*;
#(
  parameter int          LOG2_N = 10,
  parameter gng_sample_t THRESH = 16'sd6144
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               valid_in,
  input  logic signed [15:0] real_in,
  input  logic signed [15:0] imag_in,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] mean_re,
  output logic signed [15:0] mean_im,
  output logic [31:0]        pwr,
  output logic [LOG2_N+1:0]  tail_cnt
);

  localparam int SUM_W  = 16 + LOG2_N;
  localparam int PACC_W = 32 + LOG2_N;
  localparam int TC_W   = LOG2_N + 2;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  stats_state_t state_q, state_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic flush_q, flush_d;
  logic done_q, done_d;
  logic accept, clr;

  logic        vld_p2;
  gng_sample_t re_p2, im_p2;
  logic [31:0] pwr_p2;
  logic [1:0]  tail_p2;

  logic signed [SUM_W-1:0] sum_re_q, sum_re_d, sum_im_q, sum_im_d;
  logic [PACC_W-1:0]       pacc_q, pacc_d;
  logic [TC_W-1:0]         tcnt_q, tcnt_d;
  logic signed [15:0]      mean_re_q, mean_im_q;
  logic [31:0]             pwr_q;
  logic [TC_W-1:0]         tail_q;

  assign accept = valid_in && (state_q == ST_ACCUM);

  gng_cmplx_power #(.THRESH(THRESH)) u_power (
    .clk    (clk),
    .rstn   (rstn),
    .vld_i  (accept),
    .re_i   (real_in),
    .im_i   (imag_in),
    .vld_o  (vld_p2),
    .re_o   (re_p2),
    .im_o   (im_p2),
    .pwr_o  (pwr_p2),
    .tail_o (tail_p2)
  );

  // FLUSH lasts two cycles so the last sample has cleared S1 and S2 before done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FLUSH;
            flush_d = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    pacc_d   = pacc_q;
    tcnt_d   = tcnt_q;
    if (clr) begin
      sum_re_d = '0;
      sum_im_d = '0;
      pacc_d   = '0;
      tcnt_d   = '0;
    end else if (vld_p2) begin
      sum_re_d = sum_re_q + {{LOG2_N{re_p2[15]}}, re_p2};
      sum_im_d = sum_im_q + {{LOG2_N{im_p2[15]}}, im_p2};
      pacc_d   = pacc_q + {{LOG2_N{1'b0}}, pwr_p2};
      tcnt_d   = tcnt_q + {{LOG2_N{1'b0}}, tail_p2};
    end
  end

  // S3: accumulate; results load from the next-state sums so they land with done.
  // Taking the top bits is the >>> / >> by LOG2_N with truncation toward -inf.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_re_q  <= '0;
      sum_im_q  <= '0;
      pacc_q    <= '0;
      tcnt_q    <= '0;
      mean_re_q <= '0;
      mean_im_q <= '0;
      pwr_q     <= '0;
      tail_q    <= '0;
    end else begin
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
      pacc_q   <= pacc_d;
      tcnt_q   <= tcnt_d;
      if (done_d) begin
        mean_re_q <= sum_re_d[SUM_W-1 -: 16];
        mean_im_q <= sum_im_d[SUM_W-1 -: 16];
        pwr_q     <= pacc_d[PACC_W-1 -: 32];
        tail_q    <= tcnt_d;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign mean_re  = mean_re_q;
  assign mean_im  = mean_im_q;
  assign pwr      = pwr_q;
  assign tail_cnt = tail_q;

endmodule

// File: tb/tb_gng_cmplx_stats.sv
// Directed bench for gng_cmplx_stats at LOG2_N=4 (16 samples per measurement).
module tb_gng_cmplx_stats;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               valid_in;
  logic signed [15:0] real_in, imag_in;
  logic               busy, done;
  logic signed [15:0] mean_re, mean_im;
  logic [31:0]        pwr;
  logic [5:0]         tail_cnt;

  int checks = 0;
  int failures = 0;

  logic signed [15:0] re_v[16];
  logic signed [15:0] im_v[16];
  logic [69:0] res_got;

  assign res_got = {mean_re, mean_im, pwr, tail_cnt};

  gng_cmplx_stats #(.LOG2_N(4), .THRESH(16'sd6144)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .valid_in (valid_in),
    .real_in  (real_in),
    .imag_in  (imag_in),
    .busy     (busy),
    .done     (done),
    .mean_re  (mean_re),
    .mean_im  (mean_im),
    .pwr      (pwr),
    .tail_cnt (tail_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fill_alt(input logic signed [15:0] ra, input logic signed [15:0] rb,
                          input logic signed [15:0] ia, input logic signed [15:0] ib);
    for (int i = 0; i < 16; i++) begin
      re_v[i] = i[0] ? rb : ra;
      im_v[i] = i[0] ? ib : ia;
    end
  endtask

  // Presents the 16 samples, with 'gap' idle cycles between consecutive ones.
  task automatic feed(input int gap);
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      real_in  = re_v[i];
      imag_in  = im_v[i];
      step();
      valid_in = 1'b0;
      real_in  = 16'sh7fff;
      imag_in  = 16'sh7fff;
      if (i < 15)
        for (int g = 0; g < gap; g++) step();
    end
  endtask

  // lat counts cycles from the last sample's capture edge to done (3 when on time).
  task automatic wait_done(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; valid_in = 1'b0; real_in = '0; imag_in = '0;
    #2;
    checks++;
    if ({res_got, busy, done} !== 72'd0) begin
      failures++;
      $display("FAIL reset_async: got %h busy=%b done=%b, want all 0", res_got, busy, done);
    end
    step(); step();
    rstn = 1'b1;
    step();
    checks++;
    if ({res_got, busy, done} !== 72'd0) begin
      failures++;
      $display("FAIL reset_release: got %h busy=%b done=%b, want all 0", res_got, busy, done);
    end
  endtask

  task automatic test_constant();
    int lat; bit ok;
    do_start();
    checks++;
    if (busy !== 1'b1 || res_got !== 70'd0) begin
      failures++;
      $display("FAIL const_start: busy=%b res=%h, want busy=1 res=0", busy, res_got);
    end
    fill_alt(16'sd2048, 16'sd2048, -16'sd2048, -16'sd2048);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 3) begin
      failures++;
      $display("FAIL const_latency: ok=%b lat=%0d, want ok=1 lat=3", ok, lat);
    end
    checks++;
    if (res_got !== {16'h0800, 16'hF800, 32'd8388608, 6'd0}) begin
      failures++;
      $display("FAIL const_result: got %h, want %h", res_got, {16'h0800, 16'hF800, 32'd8388608, 6'd0});
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL const_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_alternating();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd6144, -16'sd6144, 16'sd0, 16'sd0);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || res_got !== {16'h0000, 16'h0000, 32'd37748736, 6'd16}) begin
      failures++;
      $display("FAIL alt_result: ok=%b got %h, want %h", ok, res_got, {16'h0000, 16'h0000, 32'd37748736, 6'd16});
    end
  endtask

  task automatic test_min_value();
    int lat; bit ok;
    do_start();
    fill_alt(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || res_got !== {16'h8000, 16'h8000, 32'h80000000, 6'd32}) begin
      failures++;
      $display("FAIL min_result: ok=%b got %h, want %h", ok, res_got, {16'h8000, 16'h8000, 32'h80000000, 6'd32});
    end
  endtask

  task automatic test_threshold_edge();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd6143, 16'sd6143, -16'sd6144, -16'sd6144);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || res_got !== {16'h17FF, 16'hE800, 32'd75485185, 6'd16}) begin
      failures++;
      $display("FAIL thresh_result: ok=%b got %h, want %h", ok, res_got, {16'h17FF, 16'hE800, 32'd75485185, 6'd16});
    end
  endtask

  task automatic test_truncation();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd0, 16'sd0, 16'sd3, 16'sd3);
    re_v[3] = -16'sd1;
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || res_got !== {16'hFFFF, 16'h0003, 32'd9, 6'd0}) begin
      failures++;
      $display("FAIL trunc_result: ok=%b got %h, want %h", ok, res_got, {16'hFFFF, 16'h0003, 32'd9, 6'd0});
    end
  endtask

  task automatic test_gaps();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd2048, 16'sd2048, -16'sd2048, -16'sd2048);
    feed(2);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 3) begin
      failures++;
      $display("FAIL gaps_latency: ok=%b lat=%0d, want ok=1 lat=3", ok, lat);
    end
    checks++;
    if (res_got !== {16'h0800, 16'hF800, 32'd8388608, 6'd0}) begin
      failures++;
      $display("FAIL gaps_result: got %h, want %h", res_got, {16'h0800, 16'hF800, 32'd8388608, 6'd0});
    end
  endtask

  task automatic test_start_while_busy();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd2048, 16'sd2048, 16'sd0, 16'sd0);
    for (int i = 8; i < 16; i++) re_v[i] = 16'sd0;
    start = 1'b1;
    feed(0);
    wait_done(lat, ok);
    start = 1'b0;
    checks++;
    if (!ok || lat != 3) begin
      failures++;
      $display("FAIL busy_start_latency: ok=%b lat=%0d, want ok=1 lat=3", ok, lat);
    end
    checks++;
    if (res_got !== {16'h0400, 16'h0000, 32'd2097152, 6'd0}) begin
      failures++;
      $display("FAIL busy_start_result: got %h, want %h", res_got, {16'h0400, 16'h0000, 32'd2097152, 6'd0});
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    do_start();
    fill_alt(16'sd2048, 16'sd2048, -16'sd2048, -16'sd2048);
    feed(0);
    wait_done(lat, ok);
    do_start();
    checks++;
    if (busy !== 1'b1 || res_got !== {16'h0800, 16'hF800, 32'd8388608, 6'd0}) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b res=%h, want busy=1 res=%h", busy, res_got, {16'h0800, 16'hF800, 32'd8388608, 6'd0});
    end
    fill_alt(16'sd6144, -16'sd6144, 16'sd0, 16'sd0);
    feed(0);
    valid_in = 1'b1;
    step();
    step();
    valid_in = 1'b0;
    checks++;
    if (done !== 1'b1 || res_got !== {16'h0000, 16'h0000, 32'd37748736, 6'd16}) begin
      failures++;
      $display("FAIL b2b_result: done=%b got %h, want done=1 %h", done, res_got, {16'h0000, 16'h0000, 32'd37748736, 6'd16});
    end
  endtask

  task automatic test_idle_valid();
    int lat; bit ok;
    int seen = 0;
    step();
    valid_in = 1'b1;
    real_in = 16'sh7fff;
    imag_in = 16'sh8000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) seen++;
    end
    valid_in = 1'b0;
    checks++;
    if (seen != 0 || res_got !== {16'h0000, 16'h0000, 32'd37748736, 6'd16}) begin
      failures++;
      $display("FAIL idle_valid: activity=%0d res=%h, want 0 and %h", seen, res_got, {16'h0000, 16'h0000, 32'd37748736, 6'd16});
    end
    do_start();
    fill_alt(16'sd2048, 16'sd2048, -16'sd2048, -16'sd2048);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || res_got !== {16'h0800, 16'hF800, 32'd8388608, 6'd0}) begin
      failures++;
      $display("FAIL idle_then_run: ok=%b got %h, want %h", ok, res_got, {16'h0800, 16'hF800, 32'd8388608, 6'd0});
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit ok;
    int seen = 0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      real_in  = 16'sd2048;
      imag_in  = 16'sd2048;
      step();
    end
    valid_in = 1'b0;
    rstn = 1'b0;
    #2;
    checks++;
    if ({res_got, busy, done} !== 72'd0) begin
      failures++;
      $display("FAIL abort_outputs: got %h busy=%b done=%b, want all 0", res_got, busy, done);
    end
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_quiet: activity=%0d cycles, want 0", seen);
    end
    do_start();
    fill_alt(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000);
    feed(0);
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != 3 || res_got !== {16'h8000, 16'h8000, 32'h80000000, 6'd32}) begin
      failures++;
      $display("FAIL abort_fresh: ok=%b lat=%0d got %h, want lat=3 %h", ok, lat, res_got, {16'h8000, 16'h8000, 32'h80000000, 6'd32});
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating();
    test_min_value();
    test_threshold_edge();
    test_truncation();
    test_gaps();
    test_start_while_busy();
    test_back_to_back();
    test_idle_valid();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
